// File: rtl/pic_pkg.sv
// pic_pkg: shared FSM states, default widths and match entry layout for the stream merger
package pic_pkg;
    localparam int PIC_IDX_W = 16;
    localparam int PIC_VAL_W = 32;
    localparam int PIC_DEPTH = 8;
    typedef enum logic [2:0] {IDLE, MERGE, FLUSH_A, FLUSH_B, DRAIN} state_t;
    typedef struct packed {
        logic [PIC_IDX_W-1:0] idx;
        logic [PIC_VAL_W-1:0] a_val;
        logic [PIC_VAL_W-1:0] b_val;
    } match_t;
endpackage

// File: rtl/pic_fifo.sv
// pic_fifo: show-ahead FIFO with occupancy level; full pushes and empty pops are ignored
module pic_fifo #(
    parameter int W     = 80,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    // storage write, deliberately left unreset
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/pic_stream_merge.sv
// pic_stream_merge: intersects two sorted sparse index streams and queues matched operand pairs
module pic_stream_merge
    import pic_pkg::*;
#(
    parameter int IDX_W = PIC_IDX_W,
    parameter int VAL_W = PIC_VAL_W,
    parameter int DEPTH = PIC_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [IDX_W-1:0]        a_idx,
    input  logic [VAL_W-1:0]        a_val,
    input  logic                    a_last,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [IDX_W-1:0]        b_idx,
    input  logic [VAL_W-1:0]        b_val,
    input  logic                    b_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_idx,
    output logic [VAL_W-1:0]        out_a_val,
    output logic [VAL_W-1:0]        out_b_val,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W:0]          match_count,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    order_err
);
    state_t              state, next;
    logic                both, a_lt, a_eq, a_end, b_end, a_fire, b_fire;
    logic                push, pop, full, empty, a_first, b_first;
    logic [IDX_W-1:0]    a_prev, b_prev;
    logic [IDX_W+2*VAL_W-1:0] fifo_dout;
    assign both      = a_valid && b_valid;
    assign a_lt      = a_idx < b_idx;
    assign a_eq      = a_idx == b_idx;
    assign a_fire    = a_valid && a_ready;
    assign b_fire    = b_valid && b_ready;
    assign a_end     = a_fire && a_last;
    assign b_end     = b_fire && b_last;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign {out_idx, out_a_val, out_b_val} = fifo_dout;
    pic_fifo #(.W(IDX_W + 2*VAL_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({a_idx, a_val, b_val}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );
    // state register
    always_ff @(posedge clk)
        state <= reset ? IDLE : next;
    // next state: leave MERGE on whichever stream delivers its last element
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? MERGE : IDLE;
            MERGE:   next = (a_end && b_end) ? DRAIN : a_end ? FLUSH_B : b_end ? FLUSH_A : MERGE;
            FLUSH_A: next = a_end ? DRAIN : FLUSH_A;
            FLUSH_B: next = b_end ? DRAIN : FLUSH_B;
            DRAIN:   next = empty ? IDLE : DRAIN;
            default: next = IDLE;
        endcase
    end
    // outputs: the smaller index advances, equal indices push only when there is room
    always_comb begin
        a_ready = (state == MERGE) ? both && (a_lt || (a_eq && !full)) : (state == FLUSH_A);
        b_ready = (state == MERGE) ? both && ((!a_lt && !a_eq) || (a_eq && !full)) : (state == FLUSH_B);
        push    = (state == MERGE) && both && a_eq && !full;
        done    = (state == DRAIN) && empty;
        busy    = state != IDLE;
    end
    // match counter and per-stream ordering monitor, restarted by start
    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
            order_err   <= 1'b0;
            a_first     <= 1'b1;
            b_first     <= 1'b1;
            a_prev      <= '0;
            b_prev      <= '0;
        end else if (state == IDLE && start) begin
            match_count <= '0;
            order_err   <= 1'b0;
            a_first     <= 1'b1;
            b_first     <= 1'b1;
        end else begin
            if (push) match_count <= match_count + (IDX_W+1)'(1);
            if (a_fire) begin
                a_first <= 1'b0;
                a_prev  <= a_idx;
                if (!a_first && a_idx <= a_prev) order_err <= 1'b1;
            end
            if (b_fire) begin
                b_first <= 1'b0;
                b_prev  <= b_idx;
                if (!b_first && b_idx <= b_prev) order_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pic_stream_merge.sv
// tb_pic_stream_merge: directed and random vector pairs checked against a two-pointer intersection model
module tb_pic_stream_merge;
    import pic_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0;
    logic        a_valid = 1'b0, a_ready, a_last = 1'b0;
    logic        b_valid = 1'b0, b_ready, b_last = 1'b0;
    logic [15:0] a_idx = '0, b_idx = '0, out_idx;
    logic [31:0] a_val = '0, b_val = '0, out_a_val, out_b_val;
    logic        out_valid, out_ready = 1'b0, busy, done, order_err;
    logic [16:0] match_count;
    logic [3:0]  fifo_level;

    int          checks = 0, errors = 0;
    int          a_q[$], b_q[$];
    logic [31:0] av_q[$], bv_q[$];
    match_t      exp_q[$];
    int          exp_cnt, n_out, ai, bi;
    int          valid_pct = 100, rdy_pct = 100;
    bit          exp_oe, start_req, reset_req = 1'b1, done_seen, any_ov;

    pic_stream_merge dut (
        .clk(clk), .reset(reset), .start(start),
        .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_val(a_val), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_val(b_val), .b_last(b_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_a_val(out_a_val), .out_b_val(out_b_val), .busy(busy), .done(done),
        .match_count(match_count), .fifo_level(fifo_level), .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        reset     = reset_req;
        start     = start_req;
        start_req = 1'b0;
        a_valid   = ai < a_q.size() && int'($urandom_range(99)) < valid_pct;
        a_idx     = ai < a_q.size() ? 16'(a_q[ai]) : '0;
        a_val     = ai < av_q.size() ? av_q[ai] : '0;
        a_last    = ai == a_q.size() - 1;
        b_valid   = bi < b_q.size() && int'($urandom_range(99)) < valid_pct;
        b_idx     = bi < b_q.size() ? 16'(b_q[bi]) : '0;
        b_val     = bi < bv_q.size() ? bv_q[bi] : '0;
        b_last    = bi == b_q.size() - 1;
        out_ready = int'($urandom_range(99)) < rdy_pct;
        @(negedge clk);
        if (a_valid && a_ready) ai++;
        if (b_valid && b_ready) bi++;
        if (out_valid) any_ov = 1'b1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_extra", 96'(n_out + 1), 96'(exp_cnt));
            else chk("out_data", {out_idx, out_a_val, out_b_val}, exp_q.pop_front());
            n_out++;
        end
        if (done) done_seen = 1'b1;
    endtask

    task automatic fill_vals();
        av_q.delete();
        bv_q.delete();
        foreach (a_q[k]) av_q.push_back($urandom);
        foreach (b_q[k]) bv_q.push_back($urandom);
    endtask

    task automatic begin_vec();
        int i = 0, j = 0;
        match_t m;
        exp_q.delete();
        while (i < a_q.size() && j < b_q.size()) begin
            if (a_q[i] < b_q[j]) i++;
            else if (a_q[i] > b_q[j]) j++;
            else begin
                m.idx = 16'(a_q[i]);
                m.a_val = av_q[i];
                m.b_val = bv_q[j];
                exp_q.push_back(m);
                i++;
                j++;
            end
        end
        exp_cnt = exp_q.size();
        exp_oe = 1'b0;
        for (int k = 1; k < a_q.size(); k++) if (a_q[k] <= a_q[k-1]) exp_oe = 1'b1;
        for (int k = 1; k < b_q.size(); k++) if (b_q[k] <= b_q[k-1]) exp_oe = 1'b1;
        ai = 0; bi = 0; n_out = 0; done_seen = 1'b0; any_ov = 1'b0;
        start_req = 1'b1;
        step();
        step();
        chk("busy_after_start", busy, 1);
        chk("match_count_cleared", match_count, 0);
        chk("order_err_cleared", order_err, 0);
    endtask

    task automatic finish_vec(input string tag);
        int cyc = 0;
        while (!done_seen && cyc < 3000) begin
            step();
            cyc++;
        end
        chk({tag, "_done_seen"}, done_seen, 1);
        chk({tag, "_match_count"}, match_count, exp_cnt);
        chk({tag, "_order_err"}, order_err, exp_oe);
        chk({tag, "_outputs"}, n_out, exp_cnt);
        chk({tag, "_level_at_done"}, fifo_level, 0);
        chk({tag, "_any_out_valid"}, any_ov, exp_cnt > 0);
        step();
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_idle_after"}, busy, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_a_ready"}, a_ready, 0);
        chk({tag, "_b_ready"}, b_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_match_count"}, match_count, 0);
        chk({tag, "_fifo_level"}, fifo_level, 0);
        chk({tag, "_order_err"}, order_err, 0);
    endtask

    initial begin
        int cyc;
        step();
        step();
        check_reset_vals("por");
        reset_req = 1'b0;
        step();

        a_q = '{1, 3, 5, 7}; b_q = '{3, 4, 7}; fill_vals();
        valid_pct = 100; rdy_pct = 100;
        begin_vec();
        finish_vec("basic");

        a_q = '{2, 4}; b_q = '{1, 9, 10, 11}; fill_vals();
        begin_vec();
        finish_vec("flush_b");

        a_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}; b_q = a_q; fill_vals();
        rdy_pct = 0;
        begin_vec();
        cyc = 0;
        while (fifo_level != 4'd8 && cyc < 60) begin
            step();
            cyc++;
        end
        step();
        step();
        chk("stall_level", fifo_level, 8);
        chk("stall_a_ready", a_ready, 0);
        chk("stall_b_ready", b_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        rdy_pct = 100;
        step();
        chk("pop_full_level", fifo_level, 8);
        chk("pop_full_push_blocked", a_ready, 0);
        rdy_pct = 0;
        step();
        chk("after_pop_level", fifo_level, 7);
        chk("after_pop_push_a", a_ready, 1);
        chk("after_pop_push_b", b_ready, 1);
        step();
        chk("refill_level", fifo_level, 8);
        rdy_pct = 100;
        finish_vec("stall");

        a_q = '{5, 3, 8}; b_q = '{3, 8}; fill_vals();
        begin_vec();
        finish_vec("order");
        repeat (3) step();
        chk("order_err_sticky", order_err, 1);

        a_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}; b_q = a_q; fill_vals();
        rdy_pct = 0;
        begin_vec();
        cyc = 0;
        while (fifo_level != 4'd3 && cyc < 60) begin
            step();
            cyc++;
        end
        chk("pre_reset_level", fifo_level, 3);
        reset_req = 1'b1;
        step();
        reset_req = 1'b0;
        a_q.delete(); b_q.delete(); exp_q.delete();
        step();
        check_reset_vals("mid_reset");
        step();

        repeat (6) begin
            a_q.delete(); b_q.delete();
            for (int k = 0; k < 24; k++) begin
                if ($urandom_range(2) == 0) a_q.push_back(k);
                if ($urandom_range(2) == 0) b_q.push_back(k);
            end
            if (a_q.size() == 0) a_q.push_back(24);
            if (b_q.size() == 0) b_q.push_back(24);
            fill_vals();
            valid_pct = 70; rdy_pct = 60;
            begin_vec();
            finish_vec("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
